// File: rtl/amber_mem_path.sv
// rtl/amber_mem_path.sv - Amber MA/MO pipeline stages with dual-port 24-bit data memory
//
// Purpose: takes a decoded memory operation from execute, performs 24-bit or
// 48-bit (two-word, both ports at once) loads and stores against an internal
// synchronous dual-port memory, and presents registered results to writeback
// two edges after capture.
//
// Ports:
//   iw_clk        clock, rising edge
//   iw_rst        synchronous active-low reset
//   iw_pc         PC of the incoming instruction (48)
//   iw_instr      instruction word (24)
//   iw_opc        memory operation code (8)
//   iw_addr       word address (48, taken mod MEM_DEPTH)
//   iw_result     24-bit operand / pass-through
//   iw_sr_result  48-bit SR operand / pass-through
//   iw_ar_result  48-bit AR operand / pass-through
//   ow_pc, ow_instr, ow_opc                      stage-delayed copies
//   ow_result, ow_sr_result, ow_ar_result        writeback results
module amber_mem_path #(
    parameter int        MEM_DEPTH = 4096,
    parameter logic [7:0] OPC_NOP  = 8'h00,
    parameter logic [7:0] OPC_LD   = 8'h01,
    parameter logic [7:0] OPC_ST   = 8'h02,
    parameter logic [7:0] OPC_SRLD = 8'h03,
    parameter logic [7:0] OPC_SRST = 8'h04,
    parameter logic [7:0] OPC_ARLD = 8'h05,
    parameter logic [7:0] OPC_ARST = 8'h06
) (
    input  logic        iw_clk,
    input  logic        iw_rst,
    input  logic [47:0] iw_pc,
    input  logic [23:0] iw_instr,
    input  logic [7:0]  iw_opc,
    input  logic [47:0] iw_addr,
    input  logic [23:0] iw_result,
    input  logic [47:0] iw_sr_result,
    input  logic [47:0] iw_ar_result,
    output logic [47:0] ow_pc,
    output logic [23:0] ow_instr,
    output logic [7:0]  ow_opc,
    output logic [23:0] ow_result,
    output logic [47:0] ow_sr_result,
    output logic [47:0] ow_ar_result
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // MA stage register
    logic [47:0] ma_pc;
    logic [23:0] ma_instr;
    logic [7:0]  ma_opc;
    logic [47:0] ma_addr;
    logic [23:0] ma_result;
    logic [47:0] ma_sr;
    logic [47:0] ma_ar;

    // MO stage register
    logic [47:0] mo_pc;
    logic [23:0] mo_instr;
    logic [7:0]  mo_opc;
    logic [23:0] mo_result;
    logic [47:0] mo_sr;
    logic [47:0] mo_ar;

    // Memory port signals, driven combinationally from the MA register
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [23:0]   wdata0;
    logic [23:0]   wdata1;
    logic          we0;
    logic          we1;
    logic [23:0]   rdata0;
    logic [23:0]   rdata1;

    logic [23:0] mem [MEM_DEPTH];

    always_comb begin
        addr0  = AW'(ma_addr % 48'(MEM_DEPTH));
        addr1  = (addr0 == AW'(MEM_DEPTH - 1)) ? '0 : addr0 + AW'(1);
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = ma_result;
        wdata1 = 24'h0;
        // Write enables are gated by reset so a store sitting in MA while
        // reset is asserted never reaches memory.
        if (iw_rst) begin
            if (ma_opc == OPC_ST) begin
                we0 = 1'b1;
            end else if (ma_opc == OPC_SRST) begin
                we0    = 1'b1;
                we1    = 1'b1;
                wdata0 = ma_sr[23:0];
                wdata1 = ma_sr[47:24];
            end else if (ma_opc == OPC_ARST) begin
                we0    = 1'b1;
                we1    = 1'b1;
                wdata0 = ma_ar[23:0];
                wdata1 = ma_ar[47:24];
            end
        end
    end

    // Memory array: never reset. Port 1 is written last so it wins a collision.
    always_ff @(posedge iw_clk) begin
        if (we0) mem[addr0] <= wdata0;
        if (we1) mem[addr1] <= wdata1;
    end

    // Read-data registers see pre-write contents (read-before-write).
    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            rdata0 <= 24'h0;
            rdata1 <= 24'h0;
        end else begin
            rdata0 <= mem[addr0];
            rdata1 <= mem[addr1];
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            ma_pc     <= 48'h0;
            ma_instr  <= 24'h0;
            ma_opc    <= OPC_NOP;
            ma_addr   <= 48'h0;
            ma_result <= 24'h0;
            ma_sr     <= 48'h0;
            ma_ar     <= 48'h0;
            mo_pc     <= 48'h0;
            mo_instr  <= 24'h0;
            mo_opc    <= OPC_NOP;
            mo_result <= 24'h0;
            mo_sr     <= 48'h0;
            mo_ar     <= 48'h0;
        end else begin
            ma_pc     <= iw_pc;
            ma_instr  <= iw_instr;
            ma_opc    <= iw_opc;
            ma_addr   <= iw_addr;
            ma_result <= iw_result;
            ma_sr     <= iw_sr_result;
            ma_ar     <= iw_ar_result;
            mo_pc     <= ma_pc;
            mo_instr  <= ma_instr;
            mo_opc    <= ma_opc;
            mo_result <= ma_result;
            mo_sr     <= ma_sr;
            mo_ar     <= ma_ar;
        end
    end

    // Writeback latch: loads substitute the read data registered alongside MO.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            ow_pc        <= 48'h0;
            ow_instr     <= 24'h0;
            ow_opc       <= OPC_NOP;
            ow_result    <= 24'h0;
            ow_sr_result <= 48'h0;
            ow_ar_result <= 48'h0;
        end else begin
            ow_pc        <= mo_pc;
            ow_instr     <= mo_instr;
            ow_opc       <= mo_opc;
            ow_result    <= (mo_opc == OPC_LD)   ? rdata0 : mo_result;
            ow_sr_result <= (mo_opc == OPC_SRLD) ? {rdata1, rdata0} : mo_sr;
            ow_ar_result <= (mo_opc == OPC_ARLD) ? {rdata1, rdata0} : mo_ar;
        end
    end

endmodule

// File: tb/tb_amber_mem_path.sv
// tb/tb_amber_mem_path.sv - self-checking bench for amber_mem_path
module tb_amber_mem_path;

    localparam int DEPTH = 4096;

    typedef struct {
        logic [47:0] pc;
        logic [23:0] instr;
        logic [7:0]  opc;
        logic [23:0] result;
        logic [47:0] sr;
        logic [47:0] ar;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [47:0] pc = '0;
    logic [23:0] instr = '0;
    logic [7:0]  opc = '0;
    logic [47:0] addr = '0;
    logic [23:0] result = '0;
    logic [47:0] sr = '0;
    logic [47:0] ar = '0;
    logic [47:0] o_pc;
    logic [23:0] o_instr;
    logic [7:0]  o_opc;
    logic [23:0] o_result;
    logic [47:0] o_sr;
    logic [47:0] o_ar;

    int n_pass = 0;
    int n_total = 0;

    logic [23:0] ref_mem [DEPTH];
    wb_t         exp_q [$];

    amber_mem_path dut (
        .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
        .iw_addr(addr), .iw_result(result), .iw_sr_result(sr), .iw_ar_result(ar),
        .ow_pc(o_pc), .ow_instr(o_instr), .ow_opc(o_opc), .ow_result(o_result),
        .ow_sr_result(o_sr), .ow_ar_result(o_ar)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Sequential semantics: each operation sees memory after all earlier ones.
    function automatic wb_t model(input logic [7:0] op, input logic [47:0] a_full,
                                  input logic [23:0] r, input logic [47:0] s,
                                  input logic [47:0] q, input logic [47:0] p,
                                  input logic [23:0] ins);
        wb_t e;
        int a  = int'(a_full % 48'(DEPTH));
        int a1 = (a + 1) % DEPTH;
        e.pc = p; e.instr = ins; e.opc = op; e.result = r; e.sr = s; e.ar = q;
        case (op)
            8'h01: e.result = ref_mem[a];
            8'h02: ref_mem[a] = r;
            8'h03: e.sr = {ref_mem[a1], ref_mem[a]};
            8'h04: begin ref_mem[a] = s[23:0]; ref_mem[a1] = s[47:24]; end
            8'h05: e.ar = {ref_mem[a1], ref_mem[a]};
            8'h06: begin ref_mem[a] = q[23:0]; ref_mem[a1] = q[47:24]; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_out(input string tag, input wb_t e);
        chk({tag, ".pc"},     o_pc,            e.pc);
        chk({tag, ".instr"},  48'(o_instr),    48'(e.instr));
        chk({tag, ".opc"},    48'(o_opc),      48'(e.opc));
        chk({tag, ".result"}, 48'(o_result),   48'(e.result));
        chk({tag, ".sr"},     o_sr,            e.sr);
        chk({tag, ".ar"},     o_ar,            e.ar);
    endtask

    task automatic step(input string tag, input logic [7:0] op, input logic [47:0] a,
                        input logic [23:0] r, input logic [47:0] s, input logic [47:0] q);
        wb_t e;
        pc = {16'($urandom), 32'($urandom)};
        instr = 24'($urandom);
        opc = op; addr = a; result = r; sr = s; ar = q;
        exp_q.push_back(model(op, a, r, s, q, pc, instr));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check_out(tag, e);
    endtask

    task automatic nop(input string tag);
        step(tag, 8'h00, {16'($urandom), 32'($urandom)}, 24'($urandom),
             {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
    endtask

    task automatic do_reset(input int n, input logic [7:0] op, input logic [47:0] a,
                            input logic [23:0] r);
        wb_t z;
        rst = 1'b0; opc = op; addr = a; result = r;
        sr = {24'($urandom), r}; ar = {24'($urandom), r};
        repeat (n) @(posedge clk);
        #1;
        z.pc = '0; z.instr = '0; z.opc = '0; z.result = '0; z.sr = '0; z.ar = '0;
        check_out("reset", z);
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [7:0]  rop;
        logic [47:0] ra;
        int          idx;

        do_reset(2, 8'h00, 48'd0, 24'd0);

        // Store survives; stores seen during or overlapping reset are dropped.
        step("st30", 8'h02, 48'd30, 24'h222222, rnd48(), rnd48());
        nop("d0"); nop("d1");
        do_reset(2, 8'h02, 48'd30, 24'h111111);
        pc = rnd48(); opc = 8'h02; addr = 48'd30; result = 24'h333333;
        @(posedge clk); #1;
        do_reset(1, 8'h00, 48'd0, 24'd0);
        step("ld30", 8'h01, 48'd30, 24'h0, rnd48(), rnd48());
        nop("d2"); nop("d3");

        // 48-bit store / loads at 12
        step("srst12", 8'h04, 48'd12, 24'h0, 48'h123456_ABCDEF, rnd48());
        nop("n0");
        step("srld12", 8'h03, 48'd12, 24'h0, rnd48(), rnd48());
        nop("n1");
        step("arld12", 8'h05, 48'd12, 24'h0, rnd48(), rnd48());
        nop("n2"); nop("n3");

        // Store then immediate load; neighbour untouched
        step("st6", 8'h02, 48'd6, 24'h0C0FFE, rnd48(), rnd48());
        step("st5", 8'h02, 48'd5, 24'h00BEEF, rnd48(), rnd48());
        step("ld5", 8'h01, 48'd5, 24'h0, rnd48(), rnd48());
        step("ld6", 8'h01, 48'd6, 24'h0, rnd48(), rnd48());

        // Wrap-around at the top of memory, with upper address bits set
        step("srst_wrap", 8'h04, {36'hF00D_CAFE_1, 12'hFFF}, 24'h0, 48'hAAAAAA_555555, rnd48());
        step("srld_wrap", 8'h03, 48'd4095, 24'h0, rnd48(), rnd48());
        step("ld0", 8'h01, 48'd0, 24'h0, rnd48(), rnd48());
        step("ld4095", 8'h01, 48'd4095, 24'h0, rnd48(), rnd48());
        step("arst_wrap", 8'h06, 48'd4095, 24'h0, rnd48(), 48'h13579B_2468AC);
        step("arld_wrap", 8'h05, 48'd4095, 24'h0, rnd48(), rnd48());

        // Initialise the random pool: words 0..15 and 4080..4095
        for (int i = 0; i < 32; i++) begin
            ra = (i < 16) ? 48'(i) : 48'(4080 + i - 16);
            step("init", 8'h02, ra, 24'($urandom), rnd48(), rnd48());
        end

        for (int i = 0; i < 400; i++) begin
            idx = int'($urandom_range(0, 30));
            ra = rnd48();
            ra[11:0] = (idx < 15) ? 12'(idx) : 12'(4080 + idx - 15);
            case ($urandom_range(0, 8))
                0: rop = 8'h00;
                1: rop = 8'h01;
                2: rop = 8'h02;
                3: rop = 8'h03;
                4: rop = 8'h04;
                5: rop = 8'h05;
                6: rop = 8'h06;
                7: rop = 8'h07;
                default: rop = 8'hFF;
            endcase
            step("rnd", rop, ra, 24'($urandom), rnd48(), rnd48());
        end
        nop("tail0"); nop("tail1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
